// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: next/jump/conditional/dispatch/spin/fetch microbranches plus retired count.
// Define MICRO_SEQUENCER_TRAP_EN to route unknown opcodes to TRAP_ADDR and raise a sticky illegal flag.
module micro_sequencer #(
  parameter int UPC_WIDTH  = 6,
  parameter int FETCH_ADDR = 0,
  parameter int TRAP_ADDR  = 2**UPC_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           ubr,
  input  logic [UPC_WIDTH-1:0] ujmp,
  input  logic                 zero,
  input  logic                 busy,
  input  logic [6:0]           opcode,
  output logic [UPC_WIDTH-1:0] upc,
  output logic                 illegal,
  output logic [31:0]          instret
);

  localparam logic [2:0] BR_N  = 3'b000;
  localparam logic [2:0] BR_J  = 3'b001;
  localparam logic [2:0] BR_EZ = 3'b010;
  localparam logic [2:0] BR_NZ = 3'b011;
  localparam logic [2:0] BR_D  = 3'b100;
  localparam logic [2:0] BR_S  = 3'b101;
  localparam logic [2:0] BR_F  = 3'b110;

`ifdef MICRO_SEQUENCER_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [UPC_WIDTH-1:0] FETCH_UPC   = UPC_WIDTH'(FETCH_ADDR);
  localparam logic [UPC_WIDTH-1:0] ILLEGAL_UPC = TRAP_EN ? UPC_WIDTH'(TRAP_ADDR) : FETCH_UPC;

  logic [UPC_WIDTH-1:0] disp_upc;
  logic [UPC_WIDTH-1:0] upc_inc;
  logic [UPC_WIDTH-1:0] next_upc;

  // Unknown opcodes fall through to the trap routine (or back to fetch when trapping is off).
  always_comb begin
    disp_upc = ILLEGAL_UPC;
    case (opcode)
      7'b0000011: disp_upc = UPC_WIDTH'(8);
      7'b0100011: disp_upc = UPC_WIDTH'(12);
      7'b0010011: disp_upc = UPC_WIDTH'(16);
      7'b0110011: disp_upc = UPC_WIDTH'(20);
      7'b1100011: disp_upc = UPC_WIDTH'(24);
      7'b1101111: disp_upc = UPC_WIDTH'(32);
      7'b1100111: disp_upc = UPC_WIDTH'(36);
      7'b0110111: disp_upc = UPC_WIDTH'(40);
      7'b0010111: disp_upc = UPC_WIDTH'(44);
      default:    disp_upc = ILLEGAL_UPC;
    endcase
  end

  // Reserved encoding 111 shares the sequential default with N.
  always_comb begin
    upc_inc  = upc + UPC_WIDTH'(1);
    next_upc = upc_inc;
    case (ubr)
      BR_J:    next_upc = ujmp;
      BR_EZ:   if (zero)  next_upc = ujmp;
      BR_NZ:   if (!zero) next_upc = ujmp;
      BR_D:    next_upc = disp_upc;
      BR_S:    if (busy)  next_upc = upc;
      BR_F:    next_upc = FETCH_UPC;
      default: next_upc = upc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc     <= FETCH_UPC;
      instret <= 32'd0;
    end else begin
      upc <= next_upc;
      if (ubr == BR_F)
        instret <= instret + 32'd1;
    end
  end

`ifdef MICRO_SEQUENCER_TRAP_EN
  logic illegal_q;

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: is_known_opcode = 1'b1;
      default:                                          is_known_opcode = 1'b0;
    endcase
  endfunction

  // Sticky until reset so software can observe a trap after the routine returns to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_q <= 1'b0;
    else if (ubr == BR_D && !is_known_opcode(opcode))
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized microbranches
// compared against an arithmetic reference model (honours MICRO_SEQUENCER_TRAP_EN).
module tb_micro_sequencer;

  localparam int UPC_WIDTH = 6;
  localparam int UPC_MOD   = 2**UPC_WIDTH;
  localparam int FETCH     = 0;
  localparam int TRAP      = UPC_MOD - 1;
  localparam longint INSTRET_MOD = 64'd4294967296;

`ifdef MICRO_SEQUENCER_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [2:0]           ubr = 3'd0;
  logic [UPC_WIDTH-1:0] ujmp = '0;
  logic                 zero = 1'b0;
  logic                 busy = 1'b0;
  logic [6:0]           opcode = 7'd0;
  logic [UPC_WIDTH-1:0] upc;
  logic                 illegal;
  logic [31:0]          instret;

  int     tests_run = 0;
  int     tests_failed = 0;
  int     m_upc;
  longint m_instret;
  bit     m_illegal;
  int     disp[int];
  int     legal_ops[9];

  micro_sequencer #(
    .UPC_WIDTH (UPC_WIDTH),
    .FETCH_ADDR(FETCH),
    .TRAP_ADDR (TRAP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ubr    (ubr),
    .ujmp   (ujmp),
    .zero   (zero),
    .busy   (busy),
    .opcode (opcode),
    .upc    (upc),
    .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input longint expected);
    tests_run++;
    if (observed !== 64'(expected)) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: one rising edge, straight from the branch rules.
  task automatic modelEdge(input int b, input int j, input bit z, input bit bs, input int op);
    int inc;
    int nxt;
    inc = (m_upc + 1) % UPC_MOD;
    case (b)
      1: nxt = j % UPC_MOD;
      2: nxt = z ? j % UPC_MOD : inc;
      3: nxt = z ? inc : j % UPC_MOD;
      4: begin
        if (disp.exists(op)) nxt = disp[op];
        else if (TRAP_ON) begin
          nxt = TRAP;
          m_illegal = 1'b1;
        end else nxt = FETCH;
      end
      5: nxt = bs ? m_upc : inc;
      6: nxt = FETCH;
      default: nxt = inc;
    endcase
    if (b == 6) m_instret = (m_instret + 1) % INSTRET_MOD;
    m_upc = nxt;
  endtask

  task automatic applyStimulus(input int b, input int j, input bit z, input bit bs, input int op);
    ubr    = 3'(b);
    ujmp   = UPC_WIDTH'(j);
    zero   = z;
    busy   = bs;
    opcode = 7'(op);
    @(posedge clk);
    modelEdge(b, j, z, bs, op);
    #1;
    checkOutput("upc", upc, m_upc);
    checkOutput("instret", instret, m_instret);
    checkOutput("illegal", illegal, m_illegal);
  endtask

  // Asynchronous reset: checked between edges, before any clock can act.
  task automatic pulseReset();
    reset = 1'b1;
    #2;
    m_upc = FETCH;
    m_instret = 0;
    m_illegal = 1'b0;
    checkOutput("reset_upc", upc, FETCH);
    checkOutput("reset_instret", instret, 0);
    checkOutput("reset_illegal", illegal, 0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    disp[7'b0000011] = 8;  disp[7'b0100011] = 12; disp[7'b0010011] = 16;
    disp[7'b0110011] = 20; disp[7'b1100011] = 24; disp[7'b1101111] = 32;
    disp[7'b1100111] = 36; disp[7'b0110111] = 40; disp[7'b0010111] = 44;
    m_upc = FETCH;
    m_instret = 0;
    m_illegal = 1'b0;

    #1;
    pulseReset();

    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1'b0, 1'b0, 0);
      checkOutput("n_count", upc, (i + 1) % 64);
    end
    checkOutput("n_instret", instret, 0);

    applyStimulus(1, 5, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5, 0, 1'b0, 1'b1, 0);
      checkOutput("spin_hold", upc, 5);
    end
    applyStimulus(5, 0, 1'b0, 1'b0, 0);
    checkOutput("spin_release", upc, 6);

    applyStimulus(4, 0, 1'b0, 1'b0, 7'b0000011);
    checkOutput("disp_load", upc, 8);
    applyStimulus(4, 0, 1'b0, 1'b0, 7'b1100011);
    checkOutput("disp_branch", upc, 24);
    applyStimulus(4, 0, 1'b0, 1'b0, 7'b0110111);
    checkOutput("disp_lui", upc, 40);

    applyStimulus(2, 30, 1'b1, 1'b0, 0);
    checkOutput("ez_taken", upc, 30);
    applyStimulus(2, 30, 1'b0, 1'b0, 0);
    checkOutput("ez_fall", upc, 31);
    applyStimulus(1, 30, 1'b0, 1'b0, 0);
    applyStimulus(3, 30, 1'b1, 1'b0, 0);
    checkOutput("nz_fall", upc, 31);
    applyStimulus(3, 30, 1'b0, 1'b0, 0);
    checkOutput("nz_taken", upc, 30);
    applyStimulus(1, 30, 1'b0, 1'b0, 0);
    checkOutput("self_loop", upc, 30);

    applyStimulus(4, 0, 1'b0, 1'b0, 7'b1111111);
    checkOutput("illegal_upc", upc, TRAP_ON ? 63 : 0);
    checkOutput("illegal_flag", illegal, TRAP_ON ? 1 : 0);
    applyStimulus(6, 0, 1'b0, 1'b0, 0);
    checkOutput("illegal_sticky", illegal, TRAP_ON ? 1 : 0);

    pulseReset();
    for (int i = 0; i < 3; i++) applyStimulus(6, 0, 1'b0, 1'b0, 0);
    checkOutput("instret_three", instret, 3);
    applyStimulus(0, 0, 1'b0, 1'b0, 0);
    pulseReset();

    for (int i = 0; i < 600; i++) begin
      int b;
      int op;
      int j;
      b  = int'($urandom_range(0, 7));
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 8)] : int'($urandom_range(0, 127));
      j  = ($urandom_range(0, 7) == 0) ? m_upc : int'($urandom_range(0, UPC_MOD - 1));
      if ($urandom_range(0, 49) == 0) pulseReset();
      else applyStimulus(b, j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter UPC_WIDTH, default 6, SHALL set the micro-PC width; it matches the state decoder's IN_WIDTH.
REQ-002 Parameter FETCH_ADDR, default 0, SHALL set the micro-address of the instruction-fetch routine.
REQ-003 Parameter TRAP_ADDR, default 2**UPC_WIDTH-1, SHALL set the micro-address of the illegal-instruction routine.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 ubr  input  3  SHALL carry the microbranch type of the current microinstruction.
REQ-007 ujmp  input  UPC_WIDTH  SHALL carry the jump/branch target micro-address.
REQ-008 zero  input  1  SHALL carry the ALU zero flag.
REQ-009 busy  input  1  SHALL carry the memory-busy flag.
REQ-010 opcode  input  7  SHALL carry IR[6:0] for dispatch.
REQ-011 upc  output  UPC_WIDTH  SHALL be the registered micro-PC, fed directly into the state decoder.
REQ-012 illegal  output  1  SHALL be the sticky illegal-opcode flag.
REQ-013 instret  output  32  SHALL be the retired-instruction count.

Function
REQ-014 next-upc SHALL be combinational from ubr/ujmp/zero/busy/opcode/upc; upc SHALL load it every rising edge (latency 1 cycle).
REQ-015 ubr=000 (N): upc+1, modulo 2**UPC_WIDTH (max value wraps to 0).
REQ-016 ubr=001 (J): ujmp.
REQ-017 ubr=010 (EZ): ujmp if zero=1, else upc+1.
REQ-018 ubr=011 (NZ): ujmp if zero=0, else upc+1.
REQ-019 ubr=100 (D): dispatch-table address for opcode (REQ-020).
REQ-020 Dispatch table SHALL be: LOAD 0000011->8, STORE 0100011->12, OP-IMM 0010011->16, OP 0110011->20, BRANCH 1100011->24, JAL 1101111->32, JALR 1100111->36, LUI 0110111->40, AUIPC 0010111->44; any other opcode is illegal (REQ-030).
REQ-021 ubr=101 (S): hold upc while busy=1; upc+1 when busy=0.
REQ-022 ubr=110 (F): FETCH_ADDR.
REQ-023 ubr=111 (reserved): SHALL behave as N.
REQ-024 instret SHALL increment by 1, wrapping at 2**32-1 to 0, on every edge where ubr=110; no other event changes it.
REQ-025 upc SHALL change only via REQ-014..023; busy and zero SHALL be ignored outside S and EZ/NZ respectively.
REQ-026 A J or EZ/NZ target equal to the current upc SHALL be legal (self-loop).

Reset
REQ-027 reset=1 SHALL immediately force upc=FETCH_ADDR, instret=0, illegal=0, regardless of clk.
REQ-028 Reset asserted mid-spin or mid-dispatch SHALL abort the routine; after deassertion the first edge computes next-upc from FETCH_ADDR.

Configuration
REQ-029 Macro MICRO_SEQUENCER_TRAP_EN SHALL select illegal-opcode handling.
REQ-030 With MICRO_SEQUENCER_TRAP_EN defined: D with illegal opcode SHALL load TRAP_ADDR and set illegal=1; illegal stays 1 until reset.
REQ-031 Without it: D with illegal opcode SHALL load FETCH_ADDR; illegal SHALL be constant 0; TRAP_ADDR unused.

Verification
REQ-032 Reset, then ubr=000 for 64 cycles -> upc 0,1,...,63,0; instret=0.
REQ-033 upc=5, ubr=101, busy=1 for 3 cycles then 0 -> upc 5,5,5,6.
REQ-034 ubr=100, opcode=0000011 -> upc=8; opcode=1100011 -> upc=24; opcode=0110111 -> upc=40.
REQ-035 ubr=010, ujmp=30, zero=1 -> upc=30; zero=0 from upc=30 -> 31; ubr=011 same cases -> opposite results.
REQ-036 ubr=100, opcode=1111111 -> with macro upc=63, illegal=1 held through later ubr=110; without macro upc=0, illegal=0.
REQ-037 Three ubr=110 edges -> instret=3; reset pulsed between clk edges -> upc=0, instret=0 before the next edge.
